pong_score_ctrl: RTL and testbench
==================================

// Module: pong_score_ctrl
// PURPOSE
//  Game/score sequencer downstream of the ball and paddle controllers. Watches the
//  6-bit ball and paddle grid positions, detects a miss at either end column,
//  updates per-player scores, and drives o_Game_Active, which recentres and
//  freezes the ball. Feeds score digits to the 7-seg driver.
// PARAMETERS
//  c_GAME_WIDTH     40       playfield columns; P1 column 0, P2 column c_GAME_WIDTH-1
//  c_PADDLE_HEIGHT  6        paddle length in grid rows
//  c_SCORE_LIMIT    9        first player to reach this score wins (1..15)
//  c_POINT_HOLD     25000000 clocks the ball stays parked after a point (1 s @ 25 MHz)
// PORTS
//  i_Clk           in   1  system clock (25 MHz)
//  i_Rst           in   1  reset, asynchronous, active-high
//  i_Start         in   1  debounced start/serve button, level; rising edge acts
//  i_Ball_X        in   6  ball column from ball controller
//  i_Ball_Y        in   6  ball row from ball controller
//  i_Paddle_Y_P1   in   6  top row of P1 paddle
//  i_Paddle_Y_P2   in   6  top row of P2 paddle
//  o_Game_Active   out  1  1 = ball moves; 0 = ball held at centre
//  o_P1_Score      out  4  P1 score, binary
//  o_P2_Score      out  4  P2 score, binary
//  o_Winner        out  2  00 none, 01 P1 won, 10 P2 won
//  o_Point_Pulse   out  1  one-clock strobe on every scored point
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, all outputs 0, edge regs 0.
//  Start edge: r_Start_d <= i_Start; edge = i_Start & ~r_Start_d.
//  Move detect: r_Ball_X_d <= i_Ball_X; a miss is checked only in the cycle
//   i_Ball_X != r_Ball_X_d (once per ball step, never twice per step).
//  Hit test (7-bit compare, no wrap): hit = (Ball_Y >= Pad_Y) &&
//   (Ball_Y < Pad_Y + c_PADDLE_HEIGHT). Paddle extending past bottom row is legal.
//  FSM:
//   IDLE      Game_Active=0. Start edge -> RUNNING; clears scores and o_Winner.
//   RUNNING   Game_Active=1. On move to col 0 with !hit(P1): P2 score +1.
//             On move to col c_GAME_WIDTH-1 with !hit(P2): P1 score +1.
//             Either miss: o_Point_Pulse=1 next cycle, go POINT_HOLD, counter=0.
//             Score reaching c_SCORE_LIMIT: set o_Winner, go GAME_OVER instead.
//   POINT_HOLD Game_Active=0; counter counts to c_POINT_HOLD-1, then waits for
//             Start edge -> RUNNING. Start edges before count expiry are ignored.
//   GAME_OVER Game_Active=0; scores/winner held. Start edge -> IDLE-equivalent:
//             scores cleared, o_Winner=0, direct to RUNNING same transition.
//  Latency: ball move -> score/o_Game_Active change = 1 clock (registered).
//  Scores never exceed c_SCORE_LIMIT; only one player scores per event (both
//   end columns cannot occur in one step).
//  Start edge coincident with a miss in RUNNING: miss wins, edge discarded.
//  Move detect is disabled outside RUNNING (ball recentring must not score);
//   r_Ball_X_d still tracks every cycle.
//  Reset mid-game/mid-hold: immediate return to IDLE, scores 0, counter 0.
//  Counter width: $clog2(c_POINT_HOLD)+1 bits; never wraps.
// STRUCTURE
//  Shared pong package: c_GAME_WIDTH/HEIGHT, c_PADDLE_HEIGHT, state encodings
//   (IDLE, RUNNING, POINT_HOLD, GAME_OVER), winner codes.
//  One sub-module: pong_paddle_hit (combinational hit test), instanced per
//   player. FSM, counter and score regs live in this module.
// TESTING (bench uses c_POINT_HOLD=16, c_SCORE_LIMIT=3)
//  Reset mid-RUNNING with scores 2/1 -> all outputs 0 same cycle, state IDLE.
//  Start edge, ball X 1->0, Y=10, P1 pad Y=8 -> hit, no score, Game_Active stays 1.
//  Ball X 1->0, Y=20, pad Y=8 -> P2 score 1, Point_Pulse 1 clock, Game_Active 0;
//   Start at hold count 5 ignored; Start after 16 clocks -> Game_Active 1.
//  Ball X 38->39, Y=0, P2 pad Y=59 (sum 65, no wrap) -> P1 score +1.
//  Ball held at X=0 for 100 clocks after one miss -> score increments once only.
//  P1 reaches 3 -> o_Winner=01, GAME_OVER; Start edge -> scores 0/0, RUNNING.

Source files
------------

// File: rtl/pong_score_ctrl_pkg.sv
// Shared pong constants: playfield geometry, score FSM states and winner codes.
package pong_score_ctrl_pkg;

   localparam int c_DEF_GAME_WIDTH    = 40;
   localparam int c_DEF_GAME_HEIGHT   = 30;
   localparam int c_DEF_PADDLE_HEIGHT = 6;
   localparam int c_DEF_SCORE_LIMIT   = 9;
   localparam int c_DEF_POINT_HOLD    = 25000000;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RUNNING    = 2'd1,
      POINT_HOLD = 2'd2,
      GAME_OVER  = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational paddle hit test; 7-bit compare so a paddle hanging past the
// bottom row never wraps back to the top.
module pong_paddle_hit #(
   parameter int c_PADDLE_HEIGHT = 6
) (
   input  logic [5:0] ball_y,
   input  logic [5:0] paddle_y,
   output logic       hit
);

   logic [6:0] ball_ext;
   logic [6:0] pad_top;
   logic [6:0] pad_end;

   assign ball_ext = {1'b0, ball_y};
   assign pad_top  = {1'b0, paddle_y};
   assign pad_end  = pad_top + 7'(c_PADDLE_HEIGHT);
   assign hit      = (ball_ext >= pad_top) && (ball_ext < pad_end);

endmodule

// File: rtl/pong_score_ctrl.sv
// Pong game/score sequencer: detects end-column misses, keeps scores, parks the
// ball between points and declares a winner.
module pong_score_ctrl
   import pong_score_ctrl_pkg::*;
#(
   parameter int c_GAME_WIDTH    = c_DEF_GAME_WIDTH,
   parameter int c_PADDLE_HEIGHT = c_DEF_PADDLE_HEIGHT,
   parameter int c_SCORE_LIMIT   = c_DEF_SCORE_LIMIT,
   parameter int c_POINT_HOLD    = c_DEF_POINT_HOLD
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Start,
   input  logic [5:0] i_Ball_X,
   input  logic [5:0] i_Ball_Y,
   input  logic [5:0] i_Paddle_Y_P1,
   input  logic [5:0] i_Paddle_Y_P2,
   output logic       o_Game_Active,
   output logic [3:0] o_P1_Score,
   output logic [3:0] o_P2_Score,
   output logic [1:0] o_Winner,
   output logic       o_Point_Pulse
);

   localparam int               c_CNT_W     = $clog2(c_POINT_HOLD) + 1;
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(c_POINT_HOLD - 1);
   localparam logic [5:0]       c_LAST_COL  = 6'(c_GAME_WIDTH - 1);
   localparam logic [3:0]       c_LIMIT     = 4'(c_SCORE_LIMIT);

   state_t             state;
   logic [c_CNT_W-1:0] hold_cnt;
   logic [1:0]         rst_pipe;
   logic               rst_core;
   logic               start_d;
   logic [5:0]         ball_x_d;
   logic               game_active;
   logic [3:0]         p1_score;
   logic [3:0]         p2_score;
   logic [1:0]         winner;
   logic               point_pulse;
   logic               hit_p1;
   logic               hit_p2;
   logic               start_edge;
   logic               ball_moved;
   logic               miss_p1;
   logic               miss_p2;
   logic [3:0]         p1_next;
   logic [3:0]         p2_next;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst_core = rst_pipe[1];

   pong_paddle_hit #(.c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)) u_hit_p1 (
      .ball_y   (i_Ball_Y),
      .paddle_y (i_Paddle_Y_P1),
      .hit      (hit_p1)
   );

   pong_paddle_hit #(.c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)) u_hit_p2 (
      .ball_y   (i_Ball_Y),
      .paddle_y (i_Paddle_Y_P2),
      .hit      (hit_p2)
   );

   assign start_edge = i_Start & ~start_d;
   assign ball_moved = (i_Ball_X != ball_x_d);
   assign miss_p1    = ball_moved && (i_Ball_X == 6'd0)       && !hit_p1;
   assign miss_p2    = ball_moved && (i_Ball_X == c_LAST_COL) && !hit_p2;
   assign p1_next    = p1_score + 4'd1;
   assign p2_next    = p2_score + 4'd1;

   always_ff @(posedge i_Clk or posedge rst_core) begin
      if (rst_core) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         start_d     <= 1'b0;
         ball_x_d    <= 6'd0;
         game_active <= 1'b0;
         p1_score    <= 4'd0;
         p2_score    <= 4'd0;
         winner      <= WIN_NONE;
         point_pulse <= 1'b0;
      end else begin
         start_d     <= i_Start;
         ball_x_d    <= i_Ball_X;
         point_pulse <= 1'b0;
         case (state)
            IDLE, GAME_OVER: begin
               if (start_edge) begin
                  p1_score    <= 4'd0;
                  p2_score    <= 4'd0;
                  winner      <= WIN_NONE;
                  game_active <= 1'b1;
                  state       <= RUNNING;
               end
            end
            RUNNING: begin
               // A miss takes priority over a coincident start press.
               if (miss_p1 || miss_p2) begin
                  point_pulse <= 1'b1;
                  game_active <= 1'b0;
                  hold_cnt    <= '0;
                  state       <= POINT_HOLD;
                  if (miss_p1) begin
                     p2_score <= p2_next;
                     if (p2_next == c_LIMIT) begin
                        winner <= WIN_P2;
                        state  <= GAME_OVER;
                     end
                  end else begin
                     p1_score <= p1_next;
                     if (p1_next == c_LIMIT) begin
                        winner <= WIN_P1;
                        state  <= GAME_OVER;
                     end
                  end
               end
            end
            POINT_HOLD: begin
               if (hold_cnt != c_HOLD_LAST) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end else if (start_edge) begin
                  game_active <= 1'b1;
                  state       <= RUNNING;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_Game_Active = game_active;
   assign o_P1_Score    = p1_score;
   assign o_P2_Score    = p2_score;
   assign o_Winner      = winner;
   assign o_Point_Pulse = point_pulse;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Scoreboard bench for pong_score_ctrl with a short hold and a score limit of 3.
module tb_pong_score_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [5:0] ball_x = 6'd20;
   logic [5:0] ball_y = 6'd10;
   logic [5:0] pad_p1 = 6'd8;
   logic [5:0] pad_p2 = 6'd59;
   logic       game_active;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] winner;
   logic       point_pulse;

   always #5 clk = ~clk;

   pong_score_ctrl #(
      .c_GAME_WIDTH    (40),
      .c_PADDLE_HEIGHT (6),
      .c_SCORE_LIMIT   (3),
      .c_POINT_HOLD    (16)
   ) dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_Start       (start),
      .i_Ball_X      (ball_x),
      .i_Ball_Y      (ball_y),
      .i_Paddle_Y_P1 (pad_p1),
      .i_Paddle_Y_P2 (pad_p2),
      .o_Game_Active (game_active),
      .o_P1_Score    (p1_score),
      .o_P2_Score    (p2_score),
      .o_Winner      (winner),
      .o_Point_Pulse (point_pulse)
   );

   typedef struct {
      bit       act;
      bit [3:0] p1;
      bit [3:0] p2;
      bit [1:0] win;
      bit       pulse;
   } exp_t;

   exp_t     sb[$];
   int       n_pass = 0;
   int       n_chk  = 0;
   bit       e_act  = 1'b0;
   bit [3:0] e_p1   = 4'd0;
   bit [3:0] e_p2   = 4'd0;
   bit [1:0] e_win  = 2'd0;

   task automatic chk(input string tag, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, got, want);
   endtask

   task automatic push_exp(input bit pulse);
      exp_t e;
      e.act = e_act; e.p1 = e_p1; e.p2 = e_p2; e.win = e_win; e.pulse = pulse;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      chk({tag, ".act"},   int'(game_active), int'(e.act));
      chk({tag, ".p1"},    int'(p1_score),    int'(e.p1));
      chk({tag, ".p2"},    int'(p2_score),    int'(e.p2));
      chk({tag, ".win"},   int'(winner),      int'(e.win));
      chk({tag, ".pulse"}, int'(point_pulse), int'(e.pulse));
   endtask

   task automatic tick(input string tag, input bit pulse = 1'b0);
      push_exp(pulse);
      @(posedge clk);
      #1;
      pop_cmp(tag);
   endtask

   // Ball steps onto column 39 past P2's paddle: P1 scores.
   task automatic score_p1();
      ball_x = 6'd38; tick("p1_approach");
      ball_y = 6'd0; ball_x = 6'd39;
      e_p1 = e_p1 + 4'd1; e_act = 1'b0;
      if (e_p1 == 4'd3) e_win = 2'b01;
      tick("p2_miss", 1'b1);
   endtask

   task automatic restart();
      start = 1'b0;
      repeat (16) tick("hold");
      start = 1'b1; e_act = 1'b1; tick("resume");
      start = 1'b0;
   endtask

   initial begin
      tick("reset");
      rst = 1'b0;
      repeat (3) tick("release");

      // Recentre-style motion before the game starts must not score.
      ball_x = 6'd0; ball_y = 6'd20; tick("idle_col0");
      ball_x = 6'd20; tick("idle_back");

      start = 1'b1; e_act = 1'b1; tick("start");
      start = 1'b0; tick("run");

      ball_x = 6'd1; ball_y = 6'd10; tick("to_col1");
      ball_x = 6'd0; tick("p1_hit");

      ball_x = 6'd1; ball_y = 6'd20; tick("to_col1b");
      ball_x = 6'd0; e_p2 = 4'd1; e_act = 1'b0; tick("p1_miss", 1'b1);
      repeat (5) tick("hold_a");
      start = 1'b1; tick("hold_early_start");
      start = 1'b0;
      repeat (12) tick("hold_b");
      start = 1'b1; e_act = 1'b1; tick("resume_a");
      start = 1'b0;

      repeat (100) tick("park_x0");

      ball_x = 6'd38; tick("to_col38");
      ball_y = 6'd62; ball_x = 6'd39; tick("p2_hit_nowrap");

      score_p1();
      restart();
      score_p1();
      restart();
      score_p1();
      repeat (20) tick("game_over");
      start = 1'b1; e_p1 = 4'd0; e_p2 = 4'd0; e_win = 2'd0; e_act = 1'b1;
      tick("new_game");
      start = 1'b0;

      score_p1();
      restart();
      ball_x = 6'd1; tick("to_col1c");
      ball_y = 6'd20; ball_x = 6'd0; start = 1'b1;
      e_p2 = 4'd1; e_act = 1'b0; tick("miss_vs_start", 1'b1);
      start = 1'b0; tick("hold_after_coincident");
      restart();
      score_p1();
      restart();

      // Asynchronous reset mid-cycle with scores 2/1.
      e_act = 1'b0; e_p1 = 4'd0; e_p2 = 4'd0; e_win = 2'd0;
      push_exp(1'b0);
      rst = 1'b1;
      #1;
      pop_cmp("rst_async");
      tick("rst_held");
      rst = 1'b0;
      repeat (3) tick("release_b");
      start = 1'b1; e_act = 1'b1; tick("start_after_rst");
      start = 1'b0; tick("run_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
